onchip_memory_arbiter: RTL and testbench
========================================

# onchip_memory_arbiter

Two-master round-robin arbiter that shares the single-port on-chip RAM (32-bit words, 10-bit word address, 1022 words, byte enables, one-cycle read latency) between two Avalon-MM style requesters. It sits between the requesters and the RAM's slave port. It issues at most one RAM access per cycle, returns read data with a `readdatavalid` strobe tagged to the issuing master, and flags out-of-range accesses.

## Interface
- `DEPTH`, 1022: number of valid RAM words; addresses >= `DEPTH` are out of range.
- `ADDR_W`, 10: word-address width.
- `DATA_W`, 32: data width; byte-enable width is `DATA_W/8`.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_address` / `m1_address`  in  `ADDR_W`  requester word address.
- `m0_byteenable` / `m1_byteenable`  in  4  write byte lanes.
- `m0_read`, `m0_write` / `m1_read`, `m1_write`  in  1 each  request strobes; read and write from the same master together is illegal.
- `m0_writedata` / `m1_writedata`  in  32  write data.
- `m0_waitrequest` / `m1_waitrequest`  out  1  request not accepted this cycle.
- `m0_readdata` / `m1_readdata`  out  32  read data, valid only with the matching `readdatavalid`.
- `m0_readdatavalid` / `m1_readdatavalid`  out  1  read data strobe.
- `mem_address`  out  `ADDR_W`  to RAM.
- `mem_byteenable`  out  4  to RAM.
- `mem_chipselect`, `mem_write`  out  1 each  to RAM.
- `mem_writedata`  out  32  to RAM.
- `mem_clken`  out  1  RAM clock enable.
- `mem_readdata`  in  32  RAM output, valid one cycle after a read issues.
- `range_err`  out  1  sticky flag, set by any out-of-range access.
- `err_clear`  in  1  synchronous clear of `range_err`.

## Operation
- Request: `mN_req = mN_read | mN_write`.
- Grant is combinational within the cycle:
  - One requester: it wins.
  - Both request: the master not granted most recently wins.
  - `last_grant` register updates on every accepted request. Reset value 1, so m0 wins the first contention.
- Winner sees `waitrequest=0` and its command is accepted at the next edge. The loser sees `waitrequest=1` and must hold its command.
- Non-requesting master: `waitrequest=0`.
- During reset, both `waitrequest` outputs are 1.
- RAM drive for the winner:
  - `mem_address`, `mem_byteenable` and `mem_writedata` are muxed from the winner.
  - `mem_chipselect = 1`; `mem_write = winner's write`.
  - No grant: `mem_chipselect = 0`, `mem_write = 0`, other `mem_*` outputs hold m0's values.
- Out of range (address >= `DEPTH`):
  - The access is still accepted (`waitrequest=0`), but `mem_chipselect` and `mem_write` are forced to 0.
  - A read still returns a `readdatavalid` pulse, with readdata 0x00000000.
  - `range_err` is set at the edge that accepts the access.
  - If `err_clear` and a new error occur in the same cycle, set wins.
- Read-return pipeline: registers `rv_valid`, `rv_owner` and `rv_oor` capture each accepted read.
  - In the following cycle, the owner's `readdatavalid` = 1 and its readdata = `mem_readdata`, or 0 if `rv_oor`.
  - The non-owner's readdata is 0.
- Writes produce no response.
- `mem_clken = ~reset`.

## Timing
- Grant and `waitrequest` have zero-cycle latency, combinational from the request inputs and `last_grant`.
- Read latency is exactly 1 cycle from the accepting edge to `readdatavalid`. Back-to-back reads sustain 1 per cycle with any mix of masters, and each response returns in issue order to the correct owner.
- A write followed by a read to the same address in the next cycle returns the new data.
- Reset values:
  - `last_grant = 1`, `rv_valid = 0`, `rv_owner = 0`, `rv_oor = 0`, `range_err = 0`.
  - All `readdatavalid` = 0 and `mem_chipselect` = 0.
- Reset asserted mid-read: the pending `readdatavalid` is dropped and is never emitted after reset releases.
- First cycle after reset deassertion: arbitration is normal.

## Test plan
- Single m0 write 0xCAFEF00D to address 5 (byteenable 0xF), then m0 read address 5 -> `m0_readdatavalid` one cycle after the read is accepted, `m0_readdata` = 0xCAFEF00D; m1 sees no valid.
- Both masters read every cycle from reset, m0 address 1 and m1 address 2 -> grants alternate m0, m1, m0, …; each master gets one valid every 2 cycles with correct data and no lost or duplicated responses.
- Byte-lane write: write 0xFFFFFFFF, then 0x00000000 with byteenable 0x5, then read -> 0xFF00FF00.
- m1 reads address 1022 -> `m1_readdatavalid` with 0x00000000, `mem_chipselect` stays 0, `range_err` = 1; pulse `err_clear` -> `range_err` = 0.
- Assert `reset` in the cycle after a read is accepted -> no `readdatavalid` ever appears; after release, m0 wins the first contention.

Source files
------------

// File: rtl/onchip_memory_arbiter_if.sv
// Bus bundle between two Avalon-MM requesters, the arbiter, and the single-port RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface onchip_memory_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] m0_address,     m1_address;
  logic [BE_W-1:0]   m0_byteenable,  m1_byteenable;
  logic              m0_read,        m1_read;
  logic              m0_write,       m1_write;
  logic [DATA_W-1:0] m0_writedata,   m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata,    m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  logic              range_err;
  logic              err_clear;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata,
    output range_err,
    input  err_clear
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata,
    input  range_err,
    output err_clear
  );
endinterface

// File: rtl/onchip_memory_arbiter.sv
// Two-master round-robin arbiter in front of a single-port one-cycle-latency RAM,
// with tagged read returns and a sticky out-of-range error flag.
module onchip_memory_arbiter #(
  parameter int unsigned DEPTH  = 1022,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  onchip_memory_arbiter_if.slave bus
);
  logic              req0, req1, gnt0, gnt1, accept;
  logic              win_read, win_write, win_oor;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] ret_data;

  logic last_grant_q, rv_valid_q, rv_owner_q, rv_oor_q, range_err_q;

  always_comb begin
    req0 = bus.m0_read | bus.m0_write;
    req1 = bus.m1_read | bus.m1_write;
    // last_grant_q holds the index of the most recently granted master.
    gnt0 = ~reset & req0 & (~req1 | last_grant_q);
    gnt1 = ~reset & req1 & (~req0 | ~last_grant_q);
    accept    = gnt0 | gnt1;
    win_addr  = gnt1 ? bus.m1_address : bus.m0_address;
    win_read  = accept & (gnt1 ? bus.m1_read : bus.m0_read);
    win_write = accept & (gnt1 ? bus.m1_write : bus.m0_write);
    win_oor   = 32'(win_addr) >= DEPTH;
    ret_data  = rv_oor_q ? '0 : bus.mem_readdata;
  end

  assign bus.m0_waitrequest = reset | (req0 & ~gnt0);
  assign bus.m1_waitrequest = reset | (req1 & ~gnt1);

  assign bus.mem_address    = win_addr;
  assign bus.mem_byteenable = gnt1 ? bus.m1_byteenable : bus.m0_byteenable;
  assign bus.mem_writedata  = gnt1 ? bus.m1_writedata : bus.m0_writedata;
  assign bus.mem_chipselect = accept & ~win_oor;
  assign bus.mem_write      = win_write & ~win_oor;
  assign bus.mem_clken      = ~reset;

  assign bus.m0_readdatavalid = rv_valid_q & ~rv_owner_q;
  assign bus.m1_readdatavalid = rv_valid_q & rv_owner_q;
  assign bus.m0_readdata      = bus.m0_readdatavalid ? ret_data : '0;
  assign bus.m1_readdata      = bus.m1_readdatavalid ? ret_data : '0;
  assign bus.range_err        = range_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rv_valid_q   <= 1'b0;
      rv_owner_q   <= 1'b0;
      rv_oor_q     <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      rv_valid_q <= win_read;
      if (accept) last_grant_q <= gnt1;
      if (win_read) begin
        rv_owner_q <= gnt1;
        rv_oor_q   <= win_oor;
      end
      // A new error in the same cycle as a clear keeps the flag set.
      range_err_q <= (accept & win_oor) | (range_err_q & ~bus.err_clear);
    end
  end
endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed, table-driven bench for onchip_memory_arbiter with a behavioural RAM.
module tb_onchip_memory_arbiter;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  onchip_memory_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  onchip_memory_arbiter #(.DEPTH(1022), .ADDR_W(10), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: reloaded while reset is high, registered read every enabled cycle.
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      ram[1]    <= 32'h1111_1111;
      ram[2]    <= 32'h2222_2222;
      ram[1022] <= 32'hDEAD_BEEF;
      bus.mem_readdata <= 32'h0;
    end else if (bus.mem_clken) begin
      if (bus.mem_chipselect && bus.mem_write)
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
      bus.mem_readdata <= ram[bus.mem_address];
    end
  end

  typedef struct {
    logic r0; logic w0; logic [9:0] a0; logic [3:0] be0; logic [31:0] wd0;
    logic r1; logic w1; logic [9:0] a1; logic [3:0] be1; logic [31:0] wd1;
    logic clr;
  } stim_t;

  typedef struct {
    logic wt0; logic wt1; logic cs; logic we; logic [9:0] maddr; logic [31:0] mwd;
    logic rdv0; logic [31:0] rd0; logic rdv1; logic [31:0] rd1; logic rerr;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic apply(input stim_t s);
    bus.m0_read = s.r0; bus.m0_write = s.w0; bus.m0_address = s.a0;
    bus.m0_byteenable = s.be0; bus.m0_writedata = s.wd0;
    bus.m1_read = s.r1; bus.m1_write = s.w1; bus.m1_address = s.a1;
    bus.m1_byteenable = s.be1; bus.m1_writedata = s.wd1;
    bus.err_clear = s.clr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  stim_t idle, both;
  int    nv0, nv1;
  logic  exp_rdv0, exp_rdv1;

  initial begin
    idle = '{1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0};
    vecs[0].s  = idle;
    vecs[0].e  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[1].s  = '{1'b0, 1'b1, 10'd5, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0};
    vecs[1].e  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd5, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[2].s  = '{1'b1, 1'b0, 10'd5, 4'hF, 32'h0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0};
    vecs[2].e  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'd5, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[3].s  = idle;
    vecs[3].e  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0};
    // m0 was granted last, so m1 wins the first contention here.
    vecs[4].s  = '{1'b1, 1'b0, 10'd1, 4'hF, 32'h0, 1'b1, 1'b0, 10'd2, 4'hF, 32'h0, 1'b0};
    vecs[4].e  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd2, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[5].s  = vecs[4].s;
    vecs[5].e  = '{1'b0, 1'b1, 1'b1, 1'b0, 10'd1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h2222_2222, 1'b0};
    vecs[6].s  = vecs[4].s;
    vecs[6].e  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd2, 32'h0, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0};
    vecs[7].s  = idle;
    vecs[7].e  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h2222_2222, 1'b0};
    vecs[8].s  = '{1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0, 1'b1, 10'd7, 4'hF, 32'hFFFF_FFFF, 1'b0};
    vecs[8].e  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd7, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[9].s  = '{1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0, 1'b1, 10'd7, 4'h5, 32'h0, 1'b0};
    vecs[9].e  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd7, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[10].s = '{1'b1, 1'b0, 10'd7, 4'hF, 32'h0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0};
    vecs[10].e = '{1'b0, 1'b0, 1'b1, 1'b0, 10'd7, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[11].s = idle;
    vecs[11].e = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 32'hFF00_FF00, 1'b0, 32'h0, 1'b0};
    vecs[12].s = '{1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 1'b0, 10'd1022, 4'hF, 32'h0, 1'b0};
    vecs[12].e = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd1022, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[13].s = idle;
    vecs[13].e = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1};
    vecs[14].s = '{1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1};
    vecs[14].e = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1};
    vecs[15].s = idle;
    vecs[15].e = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    // Clear and a new error in the same cycle: the flag must end up set.
    vecs[16].s = '{1'b0, 1'b1, 10'd1023, 4'hF, 32'h1234_5678, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1};
    vecs[16].e = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd1023, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[17].s = idle;
    vecs[17].e = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1};

    reset = 1'b1;
    apply(idle);
    #3;
    check("reset wt0", 32'(bus.m0_waitrequest), 32'd1);
    check("reset wt1", 32'(bus.m1_waitrequest), 32'd1);
    check("reset cs", 32'(bus.mem_chipselect), 32'd0);
    check("reset clken", 32'(bus.mem_clken), 32'd0);
    check("reset rdv", {30'd0, bus.m1_readdatavalid, bus.m0_readdatavalid}, 32'd0);
    check("reset rerr", 32'(bus.range_err), 32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].s);
      #3;
      check($sformatf("v%0d wt0", i), 32'(bus.m0_waitrequest), 32'(vecs[i].e.wt0));
      check($sformatf("v%0d wt1", i), 32'(bus.m1_waitrequest), 32'(vecs[i].e.wt1));
      check($sformatf("v%0d cs", i), 32'(bus.mem_chipselect), 32'(vecs[i].e.cs));
      check($sformatf("v%0d we", i), 32'(bus.mem_write), 32'(vecs[i].e.we));
      check($sformatf("v%0d maddr", i), 32'(bus.mem_address), 32'(vecs[i].e.maddr));
      check($sformatf("v%0d mwd", i), bus.mem_writedata, vecs[i].e.mwd);
      check($sformatf("v%0d rdv0", i), 32'(bus.m0_readdatavalid), 32'(vecs[i].e.rdv0));
      check($sformatf("v%0d rd0", i), bus.m0_readdata, vecs[i].e.rd0);
      check($sformatf("v%0d rdv1", i), 32'(bus.m1_readdatavalid), 32'(vecs[i].e.rdv1));
      check($sformatf("v%0d rd1", i), bus.m1_readdata, vecs[i].e.rd1);
      check($sformatf("v%0d rerr", i), 32'(bus.range_err), 32'(vecs[i].e.rerr));
      next_cycle();
    end

    // Both masters read every cycle from reset: grants alternate starting with m0.
    both = '{1'b1, 1'b0, 10'd1, 4'hF, 32'h0, 1'b1, 1'b0, 10'd2, 4'hF, 32'h0, 1'b0};
    reset = 1'b1;
    apply(both);
    #3;
    check("rr reset wt", {30'd0, bus.m1_waitrequest, bus.m0_waitrequest}, 32'd3);
    next_cycle();
    reset = 1'b0;
    nv0 = 0;
    nv1 = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) apply(idle);
      #3;
      exp_rdv0 = (k > 0) && ((k - 1) % 2 == 0);
      exp_rdv1 = (k > 0) && ((k - 1) % 2 == 1);
      if (k < 8) begin
        check($sformatf("rr%0d wt0", k), 32'(bus.m0_waitrequest), 32'(k % 2));
        check($sformatf("rr%0d wt1", k), 32'(bus.m1_waitrequest), 32'(1 - k % 2));
        check($sformatf("rr%0d maddr", k), 32'(bus.mem_address), (k % 2 == 0) ? 32'd1 : 32'd2);
      end
      check($sformatf("rr%0d rdv0", k), 32'(bus.m0_readdatavalid), 32'(exp_rdv0));
      check($sformatf("rr%0d rdv1", k), 32'(bus.m1_readdatavalid), 32'(exp_rdv1));
      check($sformatf("rr%0d rd0", k), bus.m0_readdata, exp_rdv0 ? 32'h1111_1111 : 32'h0);
      check($sformatf("rr%0d rd1", k), bus.m1_readdata, exp_rdv1 ? 32'h2222_2222 : 32'h0);
      nv0 += int'(bus.m0_readdatavalid);
      nv1 += int'(bus.m1_readdatavalid);
      next_cycle();
    end
    check("rr count0", 32'(nv0), 32'd4);
    check("rr count1", 32'(nv1), 32'd4);

    // m0 read accepted, then reset in the following cycle: the response must vanish.
    apply('{1'b1, 1'b0, 10'd1, 4'hF, 32'h0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0});
    #3;
    check("rst-rd wt0", 32'(bus.m0_waitrequest), 32'd0);
    next_cycle();
    reset = 1'b1;
    apply(idle);
    for (int k = 0; k < 2; k++) begin
      #3;
      check($sformatf("rst-rd%0d rdv", k), {30'd0, bus.m1_readdatavalid, bus.m0_readdatavalid},
            32'd0);
      next_cycle();
    end
    reset = 1'b0;
    apply(both);
    #3;
    check("post-rst wt0", 32'(bus.m0_waitrequest), 32'd0);
    check("post-rst wt1", 32'(bus.m1_waitrequest), 32'd1);
    check("post-rst rdv", {30'd0, bus.m1_readdatavalid, bus.m0_readdatavalid}, 32'd0);
    next_cycle();
    apply(idle);
    #3;
    check("post-rst rdv0", 32'(bus.m0_readdatavalid), 32'd1);
    check("post-rst rd0", bus.m0_readdata, 32'h1111_1111);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
